// File: rtl/inert_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | inert_pkg : shared types and constants for the inertial read sequencer   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package inert_pkg;

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        INIT  = 3'd1,
        IDLE  = 3'd2,
        RD    = 3'd3,
        LAST  = 3'd4
    } state_t;

    localparam int          N_INIT             = 4;
    localparam logic [15:0] INIT_CMDS [N_INIT] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
    localparam logic        RD_FLAG            = 1'b1;
    localparam int          K_W                = 4;

    // Index N_INIT (config exhausted) yields a null command word.
    function automatic logic [15:0] init_cmd(input logic [2:0] idx);
        return (idx < 3'(N_INIT)) ? INIT_CMDS[idx[1:0]] : 16'h0000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inert_rd_seq_int_sync.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | int_sync : two-flop synchroniser for the sensor data-ready line          |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/inert_rd_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | inert_rd_seq : configures an inertial sensor over SPI, then burst-reads  |
// | NUM_CH 16-bit channels per data-ready event. Rev 1.0                      |
// +---------------------------------------------------------------------------+
module inert_rd_seq
    import inert_pkg::*;
#(
    parameter bit         FAST_SIM  = 1'b1,
    parameter int         NUM_CH    = 5,
    parameter logic [6:0] BASE_ADDR = 7'h22,
    parameter bit         POLL      = 1'b0,
    parameter int         POLL_CYC  = 2400,
    parameter int         TMO_CYC   = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  INT,
    input  logic                  spi_done,
    input  logic [15:0]           spi_rd_data,
    output logic                  spi_wrt,
    output logic [15:0]           spi_cmd,
    output logic [16*NUM_CH-1:0]  data,
    output logic                  vld,
    output logic                  init_done,
    output logic                  int_tmo
);

    localparam int             N_BYTES = 2 * NUM_CH;
    localparam logic [K_W-1:0] K_LAST  = K_W'(N_BYTES - 1);
    localparam int             TW      = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int             PW      = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int             PWR_W   = FAST_SIM ? 9 : 17;

    state_t                      r_state;
    state_t                      w_next;
    logic [PWR_W-1:0]            r_pwr;
    logic [2:0]                  r_idx;
    logic [K_W-1:0]              r_k;
    logic [TW-1:0]               r_tmo;
    logic [8*(N_BYTES-1)-1:0]    r_shadow;
    logic [16*NUM_CH-1:0]        r_data;
    logic                        r_vld;
    logic                        r_init_done;
    logic                        r_int_tmo;

    logic                        w_int_s;
    logic                        w_poll_req;
    logic                        w_start;
    logic                        w_pwr_done;
    logic                        w_init_last;
    logic                        w_tmo_fire;
    logic                        w_issue;
    logic [6:0]                  w_addr;

    int_sync u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (INT),
        .o_sync  (w_int_s)
    );

    // Poll requests raised while a burst is in flight are held until IDLE.
    generate
        if (POLL) begin : g_poll
            logic [PW-1:0] r_poll_cnt;
            logic          r_poll_req;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_poll_cnt <= '0;
                    r_poll_req <= 1'b0;
                end else if (r_poll_cnt == PW'(POLL_CYC - 1)) begin
                    r_poll_cnt <= '0;
                    r_poll_req <= 1'b1;
                end else begin
                    r_poll_cnt <= r_poll_cnt + 1'b1;
                    if (r_state == IDLE) begin
                        r_poll_req <= 1'b0;
                    end
                end
            end

            assign w_poll_req = r_poll_req;
        end else begin : g_no_poll
            assign w_poll_req = 1'b0;
        end
    endgenerate

    assign w_start     = POLL ? w_poll_req : w_int_s;
    assign w_pwr_done  = &r_pwr;
    assign w_init_last = (r_state == INIT) && (r_idx == 3'(N_INIT)) && spi_done;
    assign w_tmo_fire  = !POLL && (r_state == IDLE) && !w_start && (r_tmo == TW'(TMO_CYC - 1));
    assign w_addr      = BASE_ADDR + 7'(r_k);
    assign w_issue     = spi_wrt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PWRUP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PWRUP:   if (w_pwr_done) w_next = INIT;
            INIT:    if (w_init_last) w_next = IDLE;
            IDLE: begin
                if (w_start) begin
                    w_next = RD;
                end else if (w_tmo_fire) begin
                    w_next = INIT;
                end
            end
            RD:      if (w_issue && (r_k == K_LAST)) w_next = LAST;
            LAST:    if (spi_done) w_next = IDLE;
            default: w_next = PWRUP;
        endcase
    end

    // The first read byte goes out unconditionally; the link is idle on entry from IDLE.
    always_comb begin
        spi_wrt = 1'b0;
        spi_cmd = 16'h0000;
        case (r_state)
            INIT: begin
                spi_cmd = init_cmd(r_idx);
                spi_wrt = spi_done && (r_idx < 3'(N_INIT));
            end
            RD: begin
                spi_cmd = {RD_FLAG, w_addr, 8'h00};
                spi_wrt = (r_k == '0) || spi_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwr       <= '0;
            r_idx       <= '0;
            r_k         <= '0;
            r_tmo       <= '0;
            r_shadow    <= '0;
            r_data      <= '0;
            r_vld       <= 1'b0;
            r_init_done <= 1'b0;
            r_int_tmo   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_pwr <= ((r_state == PWRUP) && !w_pwr_done) ? r_pwr + 1'b1 : '0;
            r_tmo <= (!POLL && (r_state == IDLE) && !w_start && !w_tmo_fire) ? r_tmo + 1'b1 : '0;

            if (r_state != INIT) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + 1'b1;
            end

            if (r_state != RD) begin
                r_k <= '0;
            end else if (w_issue) begin
                r_k <= r_k + 1'b1;
            end

            // Each issue returns the byte requested by the previous one.
            for (int b = 0; b < N_BYTES - 1; b++) begin
                if ((r_state == RD) && w_issue && (r_k == K_W'(b + 1))) begin
                    r_shadow[8*b +: 8] <= spi_rd_data[7:0];
                end
            end

            if ((r_state == LAST) && spi_done) begin
                r_data    <= {spi_rd_data[7:0], r_shadow};
                r_vld     <= 1'b1;
                r_int_tmo <= 1'b0;
            end

            if (w_init_last) begin
                r_init_done <= 1'b1;
            end

            if (w_tmo_fire) begin
                r_int_tmo   <= 1'b1;
                r_init_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (NUM_CH >= 1 && NUM_CH <= 8)
            else $error("inert_rd_seq: NUM_CH must lie in 1..8");
        end
    end

    assign data      = r_data;
    assign vld       = r_vld;
    assign init_done = r_init_done;
    assign int_tmo   = r_int_tmo;

endmodule
`default_nettype wire
